upcounter_ctrl: RTL and testbench

Control stage that sits directly downstream of the button debouncers. It consumes their single-cycle, edge-detected pulses and runs a run/stop/clear decimal up-counter (0–9999) off a prescaled tick. On every display-relevant change it hands a 16-bit snapshot to the SPI master through a start/done handshake, which drives the remote FND.

---
 rtl/upcounter_ctrl_if.sv | 19 +
 rtl/upcounter_ctrl.sv | 101 ++++++++++
 tb/tb_upcounter_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/upcounter_ctrl_if.sv
// upcounter_ctrl_if: start/done frame handshake toward the SPI master.
// master drives tx_start/tx_data, slave returns the one-cycle tx_done.
interface upcounter_ctrl_if;
  logic        tx_start;
  logic [15:0] tx_data;
  logic        tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_done
  );
endinterface

// File: rtl/upcounter_ctrl.sv
// upcounter_ctrl: run/stop/clear decimal up-counter with coalesced SPI frames.
// Ports: clk, rst (async low), btn_run_stop, btn_clear, tx (master), running, count.
module upcounter_ctrl #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int COUNT_MAX = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run_stop,
  input  logic             btn_clear,
  upcounter_ctrl_if.master tx,
  output logic             running,
  output logic [13:0]      count
);

  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [13:0]   CNT_LAST = 14'(COUNT_MAX);

  typedef enum logic {STOP, RUN} run_e;
  typedef enum logic {TX_IDLE, TX_WAIT} tx_e;

  run_e          run_q, run_d;
  tx_e           tx_q;
  logic [DW-1:0] div_q, div_d;
  logic [13:0]   cnt_q, cnt_d;
  logic          dirty_q;
  logic          start_q;
  logic [15:0]   data_q;
  logic          tick;
  logic          evt;

  always_comb begin
    tick  = (run_q == RUN) && (div_q == DIV_LAST);

    run_d = run_q;
    if (btn_run_stop)
      run_d = (run_q == RUN) ? STOP : RUN;

    div_d = div_q;
    if (btn_clear)
      div_d = '0;
    else if (tick)
      div_d = '0;
    else if (run_q == RUN)
      div_d = div_q + DIV_ONE;

    cnt_d = cnt_q;
    if (btn_clear)
      cnt_d = '0;
    else if (tick)
      cnt_d = (cnt_q == CNT_LAST) ? '0
                                  : cnt_q + 14'd1;

    // clear counts as an event even when count is already 0
    evt = btn_clear
        | (cnt_d != cnt_q)
        | (run_d != run_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q   <= STOP;
      div_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= TX_IDLE;
      dirty_q <= 1'b1;
      start_q <= 1'b0;
      data_q  <= '0;
    end else begin
      run_q   <= run_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      start_q <= 1'b0;
      case (tx_q)
        TX_IDLE: begin
          dirty_q <= evt;
          if (dirty_q) begin
            start_q <= 1'b1;
            data_q  <= {run_q == RUN, 1'b0, cnt_q};
            tx_q    <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          dirty_q <= dirty_q | evt;
          // done cannot belong to a frame whose start is still up
          if (tx.tx_done && !start_q)
            tx_q <= TX_IDLE;
        end
        default: tx_q <= TX_IDLE;
      endcase
    end
  end

  assign running     = (run_q == RUN);
  assign count       = cnt_q;
  assign tx.tx_start = start_q;
  assign tx.tx_data  = data_q;

endmodule

// File: tb/tb_upcounter_ctrl.sv
// tb_upcounter_ctrl: directed bench, TICK_DIV=4, COUNT_MAX=9.
// SPI master stand-in returns done 2 cycles after start unless held.
module tb_upcounter_ctrl;

  logic        clk;
  logic        rst;
  logic        btn_run_stop;
  logic        btn_clear;
  logic        running;
  logic [13:0] count;
  logic        hold;

  logic [15:0] frames [64];
  int          nfr;
  int          ctr;
  int          n_cmp;
  int          n_mis;

  upcounter_ctrl_if tx ();

  upcounter_ctrl #(
    .TICK_DIV  (4),
    .COUNT_MAX (9)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_run_stop (btn_run_stop),
    .btn_clear    (btn_clear),
    .tx           (tx),
    .running      (running),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    tx.tx_done = 1'b0;
    ctr = 0;
    nfr = 0;
    forever begin
      @(negedge clk);
      tx.tx_done = 1'b0;
      if (!rst) begin
        ctr = 0;
      end else begin
        if (!hold && ctr > 0) begin
          ctr--;
          if (ctr == 0)
            tx.tx_done = 1'b1;
        end
        if (tx.tx_start) begin
          if (nfr < 64)
            frames[nfr] = tx.tx_data;
          nfr++;
          ctr = 2;
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b0;
    btn_run_stop = 1'b0;
    btn_clear = 1'b0;
    hold = 1'b0;

    cyc(3);
    check("rst_running", 32'(running), 0);
    check("rst_count", 32'(count), 0);
    check("rst_start", 32'(tx.tx_start), 0);
    check("rst_data", 32'(tx.tx_data), 0);

    rst = 1'b1;
    cyc(8);
    check("boot_nfr", nfr, 1);
    check("boot_frame", 32'(frames[0]), 0);
    check("boot_running", 32'(running), 0);
    check("boot_count", 32'(count), 0);

    // start running: edge A
    btn_run_stop = 1'b1;
    cyc(1);
    btn_run_stop = 1'b0;
    cyc(3);
    check("run_a3_count", 32'(count), 0);
    check("run_a3_running", 32'(running), 1);
    cyc(1);
    check("run_a4_count", 32'(count), 1);
    cyc(4);
    check("run_a8_count", 32'(count), 2);
    cyc(8);
    check("run_a16_count", 32'(count), 4);
    check("run_a16_nfr", nfr, 5);
    check("frame1", 32'(frames[1]), 32'h8000);
    check("frame2", 32'(frames[2]), 32'h8001);
    check("frame4", 32'(frames[4]), 32'h8003);

    // withhold done while count moves 4 -> 7, then stop
    hold = 1'b1;
    cyc(13);
    btn_run_stop = 1'b1;
    cyc(1);
    btn_run_stop = 1'b0;
    check("hold_running", 32'(running), 0);
    check("hold_count", 32'(count), 7);
    check("hold_nfr", nfr, 6);
    check("frame5", 32'(frames[5]), 32'h8004);
    cyc(36);
    check("hold_end_nfr", nfr, 6);
    hold = 1'b0;
    cyc(6);
    check("coalesce_nfr", nfr, 7);
    check("coalesce_frame", 32'(frames[6]), 32'h0007);

    // resume: div_cnt kept 2 across STOP, edge B
    btn_run_stop = 1'b1;
    cyc(1);
    btn_run_stop = 1'b0;
    cyc(1);
    check("resume_b1_count", 32'(count), 7);
    cyc(1);
    check("resume_b2_count", 32'(count), 8);
    cyc(7);
    check("wrap_b9_count", 32'(count), 9);
    cyc(1);
    check("wrap_b10_count", 32'(count), 0);
    cyc(3);
    check("wrap_nfr", nfr, 11);
    check("frame7", 32'(frames[7]), 32'h8007);
    check("frame8", 32'(frames[8]), 32'h8008);
    check("frame9", 32'(frames[9]), 32'h8009);
    check("frame10", 32'(frames[10]), 32'h8000);

    // clear in the same cycle as a tick
    btn_clear = 1'b1;
    cyc(1);
    btn_clear = 1'b0;
    check("clr_tick_count", 32'(count), 0);
    check("clr_tick_running", 32'(running), 1);
    cyc(3);
    check("clr_b17_count", 32'(count), 0);
    cyc(1);
    check("clr_b18_count", 32'(count), 1);
    cyc(3);
    check("clr_nfr", nfr, 13);
    check("frame11", 32'(frames[11]), 32'h8000);
    check("frame12", 32'(frames[12]), 32'h8001);

    // run_stop and clear together
    btn_run_stop = 1'b1;
    btn_clear = 1'b1;
    cyc(1);
    btn_run_stop = 1'b0;
    btn_clear = 1'b0;
    check("both_running", 32'(running), 0);
    check("both_count", 32'(count), 0);
    cyc(8);
    check("both_idle_count", 32'(count), 0);
    check("both_nfr", nfr, 14);
    check("frame13", 32'(frames[13]), 32'h0000);

    // async reset while a frame is outstanding
    btn_run_stop = 1'b1;
    cyc(1);
    btn_run_stop = 1'b0;
    cyc(1);
    check("pre_rst_start", 32'(tx.tx_start), 1);
    check("pre_rst_nfr", nfr, 15);
    check("frame14", 32'(frames[14]), 32'h8000);
    rst = 1'b0;
    #2;
    check("arst_running", 32'(running), 0);
    check("arst_count", 32'(count), 0);
    check("arst_start", 32'(tx.tx_start), 0);
    check("arst_data", 32'(tx.tx_data), 0);
    cyc(2);
    rst = 1'b1;
    cyc(3);
    check("rearm_nfr", nfr, 16);
    check("frame15", 32'(frames[15]), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
